// File: rtl/ext_int_debounce.sv
// External interrupt conditioner: per-channel 2-flop synchroniser, counting debouncer,
// and a registered one-cycle interrupt pulse on accepted level changes.
module ext_int_debounce #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 0,
    parameter int EDGE_RISE       = 1,
    parameter int EDGE_FALL       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] int_ext,
    output logic [CHANNELS-1:0] btn_state
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic          INV     = (ACTIVE_LOW != 0);
    localparam logic          RISE_EN = (EDGE_RISE != 0);
    localparam logic          FALL_EN = (EDGE_FALL != 0);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] state;
    logic [CHANNELS-1:0] sample;
    logic [CHANNELS-1:0] differ;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] edge_hit;
    logic [CW-1:0]       count [CHANNELS];

    assign sample    = sync2 ^ {CHANNELS{INV}};
    assign btn_state = state;

    // A channel accepts on the edge that would otherwise push its count past TERM.
    always_comb begin
        differ   = '0;
        accept   = '0;
        edge_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            differ[i]   = (sample[i] != state[i]);
            accept[i]   = differ[i] && (count[i] == TERM);
            edge_hit[i] = accept[i] && (sample[i] ? RISE_EN : FALL_EN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            state   <= '0;
            int_ext <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            int_ext <= edge_hit;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!differ[i]) begin
                    count[i] <= '0;
                end else if (accept[i]) begin
                    state[i] <= sample[i];
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_int_debounce.sv
// Bench for ext_int_debounce: three configurations driven by shared stimulus, compared every
// cycle against a timestamp-based reference model, plus directed timing and pulse-count checks.
module tb_ext_int_debounce;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] int_d, st_d, int_b, st_b, int_a, st_a;

    always #5 clk = ~clk;

    ext_int_debounce u_def (
        .clk(clk), .reset(rst), .btn_in(btn), .int_ext(int_d), .btn_state(st_d));

    ext_int_debounce #(.EDGE_FALL(1)) u_both (
        .clk(clk), .reset(rst), .btn_in(btn), .int_ext(int_b), .btn_state(st_b));

    ext_int_debounce #(.ACTIVE_LOW(1)) u_al (
        .clk(clk), .reset(rst), .btn_in(btn), .int_ext(int_a), .btn_state(st_a));

    int  al_cfg   [3] = '{0, 0, 1};
    int  rise_cfg [3] = '{1, 1, 1};
    int  fall_cfg [3] = '{0, 1, 0};

    // Reference: a level is accepted once D consecutive edges have seen it differ from the
    // held level, i.e. D edges have elapsed since the last "quiet" edge (match, reset, accept).
    bit  m_s1 [3][2];
    bit  m_s2 [3][2];
    bit  m_st [3][2];
    bit  m_pl [3][2];
    int  mark [3][2];
    int  n = 0;

    int  pc [3][2];
    int  lp [3][2];
    int  both_seen = 0;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s inst%0d: observed %0h expected %0h (edge %0d)", tag, k, obs, exp, n);
        end
    endtask

    task automatic model_edge();
        bit smp;
        n++;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_s1[k][i] = 0; m_s2[k][i] = 0; m_st[k][i] = 0; m_pl[k][i] = 0;
                    mark[k][i] = n;
                end else begin
                    smp = m_s2[k][i] ^ (al_cfg[k] != 0);
                    m_pl[k][i] = 0;
                    if (smp == m_st[k][i]) begin
                        mark[k][i] = n;
                    end else if (n - mark[k][i] >= D) begin
                        m_pl[k][i] = smp ? (rise_cfg[k] != 0) : (fall_cfg[k] != 0);
                        m_st[k][i] = smp;
                        mark[k][i] = n;
                    end
                    m_s2[k][i] = m_s1[k][i];
                    m_s1[k][i] = btn[i];
                end
            end
        end
    endtask

    task automatic tick();
        logic [1:0] oi [3];
        logic [1:0] os [3];
        @(posedge clk);
        model_edge();
        #1;
        oi[0] = int_d; oi[1] = int_b; oi[2] = int_a;
        os[0] = st_d;  os[1] = st_b;  os[2] = st_a;
        for (int k = 0; k < 3; k++) begin
            chk("int_ext",   k, 32'(oi[k]), 32'({m_pl[k][1], m_pl[k][0]}));
            chk("btn_state", k, 32'(os[k]), 32'({m_st[k][1], m_st[k][0]}));
            for (int i = 0; i < 2; i++) begin
                if (oi[k][i] === 1'b1) begin
                    pc[k][i]++;
                    lp[k][i] = n;
                end
            end
        end
        if (int_d === 2'b11) both_seen++;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 2; i++) begin
                pc[k][i] = 0;
                lp[k][i] = -1;
            end
        both_seen = 0;
    endtask

    initial begin
        int e0;
        int hold [2];
        clear_counts();

        // Reset state
        rst = 1'b1; btn = 2'b00;
        repeat (3) tick();
        chk("reset_state", 0, 32'(st_d), 32'd0);
        chk("reset_int",   0, 32'(int_d), 32'd0);

        // Clean press on channel 0 right at reset release
        rst = 1'b0; btn = 2'b01; e0 = n; clear_counts();
        repeat (25) tick();
        chk("press_edge",   0, 32'(lp[0][0]), 32'(e0 + 18));
        chk("press_pulses", 0, 32'(pc[0][0]), 32'd1);
        chk("press_ch1",    0, 32'(pc[0][1]), 32'd0);

        // Held release: only the fall-enabled instance pulses
        btn = 2'b00; clear_counts();
        repeat (25) tick();
        chk("release_state",  0, 32'(st_d[0]), 32'd0);
        chk("release_def",    0, 32'(pc[0][0]), 32'd0);
        chk("release_fall",   1, 32'(pc[1][0]), 32'd1);

        // 15-cycle glitch rejected, 16-cycle pulse accepted
        clear_counts();
        btn = 2'b01; repeat (15) tick();
        btn = 2'b00; repeat (25) tick();
        chk("glitch15", 0, 32'(pc[0][0]), 32'd0);
        clear_counts();
        btn = 2'b01; repeat (16) tick();
        btn = 2'b00; repeat (25) tick();
        chk("pulse16", 0, 32'(pc[0][0]), 32'd1);

        // Bounce 1,0,1,1,0 then steady 1
        clear_counts();
        btn = 2'b01; tick();
        btn = 2'b00; tick();
        btn = 2'b01; tick(); tick();
        btn = 2'b00; tick();
        btn = 2'b01; e0 = n;
        repeat (25) tick();
        chk("bounce_pulses", 0, 32'(pc[0][0]), 32'd1);
        chk("bounce_edge",   0, 32'(lp[0][0]), 32'(e0 + 18));

        // Reset 8 cycles into qualification discards the transition
        btn = 2'b00; repeat (20) tick();
        clear_counts();
        btn = 2'b01; repeat (10) tick();
        rst = 1'b1; btn = 2'b00; tick();
        rst = 1'b0; repeat (25) tick();
        chk("rst_midcount", 0, 32'(pc[0][0]), 32'd0);

        // Simultaneous press on both channels
        clear_counts();
        btn = 2'b11; e0 = n;
        repeat (25) tick();
        chk("simul_ch0",  0, 32'(lp[0][0]), 32'(e0 + 18));
        chk("simul_ch1",  0, 32'(lp[0][1]), 32'(e0 + 18));
        chk("simul_both", 0, 32'(both_seen), 32'd1);

        // Active-low: pins high at release are idle; pulling low presses
        rst = 1'b1; btn = 2'b11; repeat (3) tick();
        rst = 1'b0; clear_counts();
        repeat (25) tick();
        chk("al_idle_state", 2, 32'(st_a), 32'd0);
        chk("al_idle_pulse", 2, 32'(pc[2][0] + pc[2][1]), 32'd0);
        btn = 2'b00; clear_counts();
        repeat (20) tick();
        chk("al_press_state", 2, 32'(st_a), 32'd3);
        chk("al_press_ch0",   2, 32'(pc[2][0]), 32'd1);
        chk("al_press_ch1",   2, 32'(pc[2][1]), 32'd1);

        // Random bouncing lines with occasional resets
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    btn[i]  = ~btn[i];
                    hold[i] = $urandom_range(1, 40);
                end else begin
                    hold[i]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
